// File: rtl/decoder_scan_ctrl_if.sv
// Scan-controller bus: enable/mask in, decoder select/enable out.
// SCAN_DIR_EN adds the dir input for descending scans.
interface decoder_scan_ctrl_if;
  logic       en;
  logic [7:0] digit_mask;
`ifdef SCAN_DIR_EN
  logic       dir;
`endif
  logic       a;
  logic       b;
  logic       c;
  logic       dec_en;
  logic [2:0] scan_idx;
  logic       frame_done;

`ifdef SCAN_DIR_EN
  modport master (
    output en, digit_mask, dir,
    input  a, b, c, dec_en, scan_idx, frame_done
  );
  modport slave (
    input  en, digit_mask, dir,
    output a, b, c, dec_en, scan_idx, frame_done
  );
`else
  modport master (
    output en, digit_mask,
    input  a, b, c, dec_en, scan_idx, frame_done
  );
  modport slave (
    input  en, digit_mask,
    output a, b, c, dec_en, scan_idx, frame_done
  );
`endif
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Round-robin 3-to-8 decoder scan sequencer with blank/dwell timing.
// Optional SCAN_DIR_EN: descending scan selected by bus.dir.
module decoder_scan_ctrl #(
  parameter int DWELL = 50000,
  parameter int BLANK = 16,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  decoder_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_e;

  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] DWL_LAST = CNT_W'(DWELL - 1);

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dec_en_q;
  logic             fd_q;

  logic       down;
  logic       run_ok;
  logic       wrap;
  logic [2:0] idx_d;
  logic [2:0] start_idx;

  // Search i+1, i+2, ... (or downward), with i itself lowest priority.
  function automatic logic [2:0] scan_next(
    input logic [2:0] i,
    input logic [7:0] m,
    input logic       dn
  );
    logic [2:0] r;
    logic [2:0] j;
    r = i;
    for (int k = 8; k >= 1; k--) begin
      j = dn ? i - 3'(k) : i + 3'(k);
      if (m[j]) r = j;
    end
    return r;
  endfunction

`ifdef SCAN_DIR_EN
  assign down = bus.dir;
`else
  assign down = 1'b0;
`endif

  assign run_ok    = bus.en && (|bus.digit_mask);
  assign idx_d     = scan_next(idx_q, bus.digit_mask, down);
  assign start_idx = down ? scan_next(3'd0, bus.digit_mask, 1'b1)
                          : scan_next(3'd7, bus.digit_mask, 1'b0);
  assign wrap      = down ? (idx_d >= idx_q) : (idx_d <= idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      cnt_q    <= '0;
      dec_en_q <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          dec_en_q <= 1'b0;
          cnt_q    <= '0;
          if (run_ok) begin
            state_q <= S_BLANK;
            idx_q   <= start_idx;
          end
        end
        S_BLANK: begin
          if (!run_ok) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dec_en_q <= 1'b0;
          end else if (cnt_q == BLK_LAST) begin
            state_q  <= S_SHOW;
            cnt_q    <= '0;
            dec_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (!run_ok) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dec_en_q <= 1'b0;
          end else if (cnt_q == DWL_LAST) begin
            state_q  <= S_BLANK;
            cnt_q    <= '0;
            dec_en_q <= 1'b0;
            idx_q    <= idx_d;
            fd_q     <= wrap;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          dec_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a          = idx_q[2];
  assign bus.b          = idx_q[1];
  assign bus.c          = idx_q[0];
  assign bus.scan_idx   = idx_q;
  assign bus.dec_en     = dec_en_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl (DWELL=4, BLANK=2) with a
// period-position reference model checked every cycle.
module tb_decoder_scan_ctrl;

  localparam int DW  = 4;
  localparam int BL  = 2;
  localparam int PER = DW + BL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dir = 1'b0;

  decoder_scan_ctrl_if bus ();

`ifdef SCAN_DIR_EN
  assign bus.dir = dir;
`endif

  decoder_scan_ctrl #(
    .DWELL(DW),
    .BLANK(BL),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", nm, got, exp);
  endtask

  // Reference: active flag, index and position within the period.
  bit m_act = 1'b0;
  int m_idx = 0;
  int m_pos = 0;
  bit m_fd  = 1'b0;

  function automatic int first_idx(input logic [7:0] m, input bit dn);
    for (int j = 0; j < 8; j++) begin
      int b;
      b = dn ? 7 - j : j;
      if (m[b]) return b;
    end
    return 0;
  endfunction

  function automatic int step_idx(input int i, input logic [7:0] m,
                                  input bit dn);
    for (int k = 1; k <= 8; k++) begin
      int j;
      j = dn ? (i - k + 8) % 8 : (i + k) % 8;
      if (m[j]) return j;
    end
    return i;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0;
      m_idx <= 0;
      m_pos <= 0;
      m_fd  <= 1'b0;
    end else begin
      m_fd <= 1'b0;
      if (!m_act) begin
        if (bus.en && bus.digit_mask != 0) begin
          m_act <= 1'b1;
          m_idx <= first_idx(bus.digit_mask, dir);
          m_pos <= 0;
        end
      end else if (!bus.en || bus.digit_mask == 0) begin
        m_act <= 1'b0;
      end else if (m_pos == PER - 1) begin
        int n;
        n = step_idx(m_idx, bus.digit_mask, dir);
        m_pos <= 0;
        m_idx <= n;
        m_fd  <= dir ? (n >= m_idx) : (n <= m_idx);
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_idx", 32'(bus.scan_idx), 32'(m_idx));
      check("cyc_abc", 32'({bus.a, bus.b, bus.c}), 32'(m_idx));
      check("cyc_den", 32'(bus.dec_en), 32'(m_act && m_pos >= BL));
      check("cyc_fd", 32'(bus.frame_done), 32'(m_fd));
    end
  end

  int   shown[$];
  logic de_q[$];
  int   fdcnt;

  task automatic run(input int n);
    logic prev;
    shown.delete();
    de_q.delete();
    fdcnt = 0;
    prev  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.dec_en && !prev) shown.push_back(int'(bus.scan_idx));
      if (bus.frame_done) fdcnt++;
      de_q.push_back(bus.dec_en);
      prev = bus.dec_en;
    end
  endtask

  task automatic restart(input logic [7:0] m);
    @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    bus.digit_mask = m;
    bus.en = 1'b1;
  endtask

  task automatic wait_for(input int wi, input logic wd, input string nm);
    int  k;
    bit  hit;
    k   = 0;
    hit = 1'b0;
    while (!hit && k < 200) begin
      @(negedge clk);
      hit = (bus.scan_idx == 3'(wi)) && (bus.dec_en == wd);
      k++;
    end
    check(nm, 32'(hit), 32'd1);
  endtask

  initial begin
    int exp3[4];
    exp3 = '{2, 5, 7, 2};
    bus.en = 1'b0;
    bus.digit_mask = 8'h00;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_abc", 32'({bus.a, bus.b, bus.c}), 32'd0);
    check("idle_den", 32'(bus.dec_en), 32'd0);
    check("idle_fd", 32'(bus.frame_done), 32'd0);

    // 2: full scan
    restart(8'hFF);
    run(49);
    check("full_cnt", 32'(shown.size()), 32'd8);
    for (int i = 0; i < 8 && i < shown.size(); i++)
      check("full_seq", 32'(shown[i]), 32'(i));
    check("full_fd", 32'(fdcnt), 32'd1);

    // 3: sparse mask
    restart(8'b1010_0100);
    run(21);
    check("sparse_cnt", 32'(shown.size()), 32'd4);
    for (int i = 0; i < 4 && i < shown.size(); i++)
      check("sparse_seq", 32'(shown[i]), 32'(exp3[i]));
    check("sparse_fd", 32'(fdcnt), 32'd1);

    // 4: single bit
    restart(8'h10);
    run(6);
    check("single_pat", 32'({de_q[0], de_q[1], de_q[2],
                             de_q[3], de_q[4], de_q[5]}), 32'b001111);
    run(12);
    check("single_fd", 32'(fdcnt), 32'd2);
    check("single_idx", 32'(bus.scan_idx), 32'd4);

    // 5a: en drop mid-SHOW at idx 3
    restart(8'hFF);
    wait_for(3, 1'b1, "wait_show3");
    bus.en = 1'b0;
    @(negedge clk);
    check("endrop_den", 32'(bus.dec_en), 32'd0);
    check("endrop_idx", 32'(bus.scan_idx), 32'd3);
    // 5b: en restored restarts at 0 with blank first
    bus.en = 1'b1;
    @(negedge clk);
    check("resume_idx", 32'(bus.scan_idx), 32'd0);
    check("resume_den0", 32'(bus.dec_en), 32'd0);
    @(negedge clk);
    check("resume_den1", 32'(bus.dec_en), 32'd0);
    @(negedge clk);
    check("resume_den2", 32'(bus.dec_en), 32'd1);
    // 5c: mask cleared mid-BLANK
    wait_for(2, 1'b0, "wait_blank2");
    bus.digit_mask = 8'h00;
    run(10);
    check("mask0_show", 32'(shown.size()), 32'd0);
    check("mask0_fd", 32'(fdcnt), 32'd0);
    check("mask0_idx", 32'(bus.scan_idx), 32'd2);
    // 5d: reset mid-SHOW
    restart(8'hFF);
    wait_for(1, 1'b1, "wait_show1");
    rst = 1'b1;
    @(negedge clk);
    check("rst_idx", 32'(bus.scan_idx), 32'd0);
    check("rst_den", 32'(bus.dec_en), 32'd0);
    check("rst_fd", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;

`ifdef SCAN_DIR_EN
    // 6: descending scan
    dir = 1'b1;
    restart(8'hFF);
    run(49);
    check("down_cnt", 32'(shown.size()), 32'd8);
    for (int i = 0; i < 8 && i < shown.size(); i++)
      check("down_seq", 32'(shown[i]), 32'(7 - i));
    check("down_fd", 32'(fdcnt), 32'd1);
    dir = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
